// File: rtl/active_list_pkg.sv
// Shared widths, entry layout and FSM encoding for the active list.
package active_list_pkg;

  localparam int DEPTH  = 32;
  localparam int TAG_W  = $clog2(DEPTH);
  localparam int CNT_W  = TAG_W + 1;
  localparam int PHYS_W = 6;
  localparam int ARCH_W = 5;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [PHYS_W-1:0] phys_t;
  typedef logic [ARCH_W-1:0] arch_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    arch_t arch_rd;
    phys_t new_phys;
    phys_t old_phys;
  } al_entry_t;

  typedef enum logic [1:0] {
    AL_RUN    = 2'd0,
    AL_WALK   = 2'd1,
    AL_REVERT = 2'd2
  } al_state_t;

  // Ring-buffer pointer advance; wraps naturally because DEPTH is a power of two.
  function automatic tag_t tag_inc(input tag_t t);
    return t + tag_t'(1);
  endfunction

  function automatic tag_t tag_dec(input tag_t t);
    return t - tag_t'(1);
  endfunction

endpackage

// File: rtl/active_list_if.sv
// Rename/execute/free-list side signals of the active list, grouped as one bundle.
interface active_list_if;
  import active_list_pkg::*;

  logic  alloc_valid;
  logic  alloc_ready;
  arch_t alloc_arch_rd;
  phys_t alloc_new_phys;
  phys_t alloc_old_phys;
  tag_t  alloc_tag;

  logic  done_valid;
  tag_t  done_tag;

  logic  flush_valid;
  tag_t  flush_tag;

  logic  free_w_en;
  phys_t free_dat;

  logic  restore_valid;
  arch_t restore_arch_rd;
  phys_t restore_phys;

  logic  revert;
  cnt_t  revert_cnt;

  logic  busy;
  logic  empty;
  logic  full;

  modport slave (
    input  alloc_valid, alloc_arch_rd, alloc_new_phys, alloc_old_phys,
    input  done_valid, done_tag, flush_valid, flush_tag,
    output alloc_ready, alloc_tag, free_w_en, free_dat,
    output restore_valid, restore_arch_rd, restore_phys,
    output revert, revert_cnt, busy, empty, full
  );

  modport master (
    output alloc_valid, alloc_arch_rd, alloc_new_phys, alloc_old_phys,
    output done_valid, done_tag, flush_valid, flush_tag,
    input  alloc_ready, alloc_tag, free_w_en, free_dat,
    input  restore_valid, restore_arch_rd, restore_phys,
    input  revert, revert_cnt, busy, empty, full
  );

endinterface

// File: rtl/active_list.sv
// In-order tracker of renamed instructions: commits return old phys regs to the
// free list, flushes walk younger entries back and emit map-table restores.
//
// state     | meaning
// AL_RUN    | normal operation: alloc, done, commit, flush accept
// AL_WALK   | squash one younger entry per cycle from the tail, restoring its mapping
// AL_REVERT | one-cycle revert pulse to the free list, then back to AL_RUN
module active_list
  import active_list_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  active_list_if.slave bus
);

  al_state_t state_q, state_d;
  tag_t      head_q, head_d;
  tag_t      tail_q, tail_d;
  tag_t      stop_q, stop_d;
  cnt_t      count_q, count_d;
  cnt_t      walk_cnt_q, walk_cnt_d;
  al_entry_t mem_q [DEPTH];

  logic  free_w_en_q, free_w_en_d;
  phys_t free_dat_q, free_dat_d;
  logic  restore_valid_q, restore_valid_d;
  arch_t restore_arch_q, restore_arch_d;
  phys_t restore_phys_q, restore_phys_d;
  logic  revert_q, revert_d;
  cnt_t  revert_cnt_q, revert_cnt_d;

  logic alloc_ready;
  logic alloc_fire;
  logic commit;
  logic flush_acc;
  logic walk_step;
  tag_t walk_idx;
  tag_t flush_stop;

  assign alloc_ready = (count_q != cnt_t'(DEPTH)) && (state_q == AL_RUN);
  assign flush_acc   = (state_q == AL_RUN) && bus.flush_valid && mem_q[bus.flush_tag].valid;
  // A flush in the same cycle squashes the incoming alloc; rename drops it too.
  assign alloc_fire  = bus.alloc_valid && alloc_ready && !flush_acc;
  assign commit      = (state_q == AL_RUN) && (count_q != '0) &&
                       mem_q[head_q].valid && mem_q[head_q].done;
  assign walk_idx    = tag_dec(tail_q);
  assign flush_stop  = tag_inc(bus.flush_tag);

  always_comb begin
    state_d         = state_q;
    head_d          = head_q;
    tail_d          = tail_q;
    stop_d          = stop_q;
    walk_cnt_d      = walk_cnt_q;
    walk_step       = 1'b0;
    free_w_en_d     = 1'b0;
    free_dat_d      = free_dat_q;
    restore_valid_d = 1'b0;
    restore_arch_d  = restore_arch_q;
    restore_phys_d  = restore_phys_q;
    revert_d        = 1'b0;
    revert_cnt_d    = revert_cnt_q;

    case (state_q)
      AL_RUN: begin
        if (commit) begin
          free_w_en_d = 1'b1;
          free_dat_d  = mem_q[head_q].old_phys;
          head_d      = tag_inc(head_q);
        end
        if (alloc_fire) begin
          tail_d = tag_inc(tail_q);
        end
        if (flush_acc) begin
          stop_d     = flush_stop;
          walk_cnt_d = '0;
          // Flushing the youngest entry leaves nothing to walk.
          state_d    = (tail_q == flush_stop) ? AL_REVERT : AL_WALK;
        end
      end
      AL_WALK: begin
        walk_step       = 1'b1;
        restore_valid_d = 1'b1;
        restore_arch_d  = mem_q[walk_idx].arch_rd;
        restore_phys_d  = mem_q[walk_idx].old_phys;
        tail_d          = walk_idx;
        walk_cnt_d      = walk_cnt_q + cnt_t'(1);
        if (walk_idx == stop_q) begin
          state_d = AL_REVERT;
        end
      end
      AL_REVERT: begin
        revert_d     = 1'b1;
        revert_cnt_d = walk_cnt_q;
        state_d      = AL_RUN;
      end
      default: begin
        state_d = AL_RUN;
      end
    endcase

    count_d = count_q;
    if (alloc_fire && !commit) begin
      count_d = count_q + cnt_t'(1);
    end else if (commit && !alloc_fire) begin
      count_d = count_q - cnt_t'(1);
    end
    if (walk_step) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= AL_RUN;
      head_q          <= '0;
      tail_q          <= '0;
      stop_q          <= '0;
      count_q         <= '0;
      walk_cnt_q      <= '0;
      free_w_en_q     <= 1'b0;
      free_dat_q      <= '0;
      restore_valid_q <= 1'b0;
      restore_arch_q  <= '0;
      restore_phys_q  <= '0;
      revert_q        <= 1'b0;
      revert_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      stop_q          <= stop_d;
      count_q         <= count_d;
      walk_cnt_q      <= walk_cnt_d;
      free_w_en_q     <= free_w_en_d;
      free_dat_q      <= free_dat_d;
      restore_valid_q <= restore_valid_d;
      restore_arch_q  <= restore_arch_d;
      restore_phys_q  <= restore_phys_d;
      revert_q        <= revert_d;
      revert_cnt_q    <= revert_cnt_d;
    end
  end

  // Later assignments win: a squashed or committed slot ends invalid even if done lands the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (bus.done_valid && mem_q[bus.done_tag].valid) begin
        mem_q[bus.done_tag].done <= 1'b1;
      end
      if (commit) begin
        mem_q[head_q].valid <= 1'b0;
      end
      if (walk_step) begin
        mem_q[walk_idx].valid <= 1'b0;
      end
      if (alloc_fire) begin
        mem_q[tail_q] <= '{valid:    1'b1,
                           done:     1'b0,
                           arch_rd:  bus.alloc_arch_rd,
                           new_phys: bus.alloc_new_phys,
                           old_phys: bus.alloc_old_phys};
      end
    end
  end

  assign bus.alloc_ready     = alloc_ready;
  assign bus.alloc_tag       = tail_q;
  assign bus.free_w_en       = free_w_en_q;
  assign bus.free_dat        = free_dat_q;
  assign bus.restore_valid   = restore_valid_q;
  assign bus.restore_arch_rd = restore_arch_q;
  assign bus.restore_phys    = restore_phys_q;
  assign bus.revert          = revert_q;
  assign bus.revert_cnt      = revert_cnt_q;
  assign bus.busy            = (state_q != AL_RUN);
  assign bus.empty           = (count_q == '0);
  assign bus.full            = (count_q == cnt_t'(DEPTH));

endmodule

// File: tb/tb_active_list.sv
// Scoreboard bench for active_list: expected frees, restores and reverts are queued
// by the stimulus and popped by a monitor whenever the DUT strobes them.
module tb_active_list;
  import active_list_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [5:0]  free_q [$];
  logic [10:0] rest_q [$];
  logic [5:0]  rev_q  [$];

  active_list_if bus ();

  active_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input int tag, input int arch, input int newp, input int oldp);
    bus.alloc_valid    = 1'b1;
    bus.alloc_arch_rd  = arch_t'(arch);
    bus.alloc_new_phys = phys_t'(newp);
    bus.alloc_old_phys = phys_t'(oldp);
    chk("alloc_ready", int'(bus.alloc_ready), 1);
    chk("alloc_tag", int'(bus.alloc_tag), tag);
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic done(input int tag);
    bus.done_valid = 1'b1;
    bus.done_tag   = tag_t'(tag);
    tick();
    bus.done_valid = 1'b0;
  endtask

  task automatic flush(input int tag);
    bus.flush_valid = 1'b1;
    bus.flush_tag   = tag_t'(tag);
    tick();
    bus.flush_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.busy && n < limit) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (!bus.empty && n < limit) begin
      tick();
      n++;
    end
    chk("empty_timeout", int'(bus.empty), 1);
  endtask

  task automatic push_rest(input int arch, input int phys);
    rest_q.push_back({arch_t'(arch), phys_t'(phys)});
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.free_w_en === 1'b1) begin
      if (free_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL free_unexpected: got dat %0d expected no free", bus.free_dat);
      end else begin
        chk("free_dat", int'(bus.free_dat), int'(free_q.pop_front()));
      end
    end
    if (bus.restore_valid === 1'b1) begin
      if (rest_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL restore_unexpected: got arch %0d phys %0d expected none",
                 bus.restore_arch_rd, bus.restore_phys);
      end else begin
        chk("restore_arch_phys", int'({bus.restore_arch_rd, bus.restore_phys}),
            int'(rest_q.pop_front()));
      end
    end
    if (bus.revert === 1'b1) begin
      if (rev_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL revert_unexpected: got cnt %0d expected no revert", bus.revert_cnt);
      end else begin
        chk("revert_cnt", int'(bus.revert_cnt), int'(rev_q.pop_front()));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n              = 1'b0;
    bus.alloc_valid    = 1'b0;
    bus.alloc_arch_rd  = '0;
    bus.alloc_new_phys = '0;
    bus.alloc_old_phys = '0;
    bus.done_valid     = 1'b0;
    bus.done_tag       = '0;
    bus.flush_valid    = 1'b0;
    bus.flush_tag      = '0;

    // Reset state
    do_reset();
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_ready", int'(bus.alloc_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tag", int'(bus.alloc_tag), 0);
    chk("rst_free_w_en", int'(bus.free_w_en), 0);
    chk("rst_restore", int'(bus.restore_valid), 0);
    chk("rst_revert", int'(bus.revert), 0);

    // Out-of-order completion, in-order commit; tag 2 never completes
    alloc(0, 1, 1, 40);
    alloc(1, 2, 2, 41);
    alloc(2, 3, 3, 42);
    free_q.push_back(6'd40);
    free_q.push_back(6'd41);
    done(1);
    done(0);
    repeat (6) tick();
    chk("t1_empty", int'(bus.empty), 0);
    chk("t1_tag", int'(bus.alloc_tag), 3);

    // Full boundary
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(i, i, i, i);
    chk("t2_full", int'(bus.full), 1);
    chk("t2_ready_full", int'(bus.alloc_ready), 0);
    free_q.push_back(6'd0);
    done(0);
    chk("t2_ready_still_full", int'(bus.alloc_ready), 0);
    tick();
    chk("t2_full_after", int'(bus.full), 0);
    chk("t2_ready_after", int'(bus.alloc_ready), 1);
    chk("t2_tag_after", int'(bus.alloc_tag), 0);

    // Flush walk of three younger entries
    do_reset();
    for (int i = 0; i < 5; i++) alloc(i, i + 1, 20 + i, 10 + i);
    push_rest(5, 14);
    push_rest(4, 13);
    push_rest(3, 12);
    rev_q.push_back(6'd3);
    flush(1);
    chk("t3_busy", int'(bus.busy), 1);
    wait_idle(20);
    chk("t3_tail", int'(bus.alloc_tag), 2);

    // Flush on youngest: revert only
    rev_q.push_back(6'd0);
    flush(1);
    wait_idle(5);
    chk("t4_tail", int'(bus.alloc_tag), 2);
    chk("t4_empty", int'(bus.empty), 0);

    // Wrap-around walk
    do_reset();
    for (int i = 0; i < 30; i++) alloc(i, i, i, i);
    for (int i = 0; i < 30; i++) begin
      free_q.push_back(6'(i));
      done(i);
    end
    wait_empty(10);
    chk("t5_head_tail", int'(bus.alloc_tag), 30);
    alloc(30, 7, 1, 50);
    alloc(31, 8, 2, 51);
    alloc(0, 9, 3, 52);
    alloc(1, 10, 4, 53);
    push_rest(10, 53);
    push_rest(9, 52);
    push_rest(8, 51);
    rev_q.push_back(6'd3);
    flush(30);
    wait_idle(20);
    chk("t5_tail", int'(bus.alloc_tag), 31);

    // Stale done and second flush during WALK are ignored
    alloc(31, 11, 5, 20);
    alloc(0, 12, 6, 21);
    alloc(1, 13, 7, 22);
    alloc(2, 14, 8, 23);
    push_rest(14, 23);
    push_rest(13, 22);
    push_rest(12, 21);
    rev_q.push_back(6'd3);
    flush(31);
    flush(30);
    done(2);
    wait_idle(20);
    chk("t6_tail", int'(bus.alloc_tag), 0);
    free_q.push_back(6'd50);
    done(30);
    tick();
    free_q.push_back(6'd20);
    done(31);
    wait_empty(10);

    // Reset mid-walk aborts with no revert
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i, i + 1, i, 60 + i);
    push_rest(4, 63);
    flush(0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_empty", int'(bus.empty), 1);
    chk("t7_busy", int'(bus.busy), 0);
    chk("t7_restore", int'(bus.restore_valid), 0);
    chk("t7_tag", int'(bus.alloc_tag), 0);
    repeat (6) tick();

    chk("left_free", free_q.size(), 0);
    chk("left_restore", rest_q.size(), 0);
    chk("left_revert", rev_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
